// File: rtl/exec_pkg.sv
// exec_pkg -- shared types and constants for the execute stage.
//   alu_op_t     : ALUControlE encodings
//   cond_t       : ARM condition field encodings
//   fwd_sel_t    : ForwardAE/ForwardBE operand source selects
//   exec_state_t : multiply sequencer states (exposed on DbgStateE)
//   FLAG_*       : bit positions of N,Z,C,V inside FlagsQ
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_MOV  = 3'b110,
    ALU_ZERO = 3'b111
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
    COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
  } cond_t;

  typedef enum logic [1:0] {
    FWD_RD     = 2'b00,
    FWD_WB     = 2'b01,
    FWD_MEM    = 2'b10,
    FWD_RD_ALT = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } exec_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_alu.sv
// exec_alu -- combinational ALU with N,Z,C,V generation.
//   i_a, i_b      : operands (SrcA, SrcB)
//   i_op          : alu_op_t select
//   i_mul_prod    : result presented for the MUL op (product or zero)
//   o_result      : ALU result
//   o_n, o_z      : sign / zero of o_result
//   o_c, o_v      : carry / signed overflow (ADD, SUB only)
//   o_cv_upd      : 1 when the op is allowed to change C,V
module exec_alu
  import exec_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic [2:0]      i_op,
  input  logic [BITS-1:0] i_mul_prod,
  output logic [BITS-1:0] o_result,
  output logic            o_n,
  output logic            o_z,
  output logic            o_c,
  output logic            o_v,
  output logic            o_cv_upd
);

  logic [BITS:0]   w_sum;
  logic [BITS-1:0] w_result;

  always_comb begin
    w_sum    = '0;
    w_result = '0;
    o_c      = 1'b0;
    o_v      = 1'b0;
    o_cv_upd = 1'b0;
    case (alu_op_t'(i_op))
      ALU_ADD: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        w_result = w_sum[BITS-1:0];
        o_c      = w_sum[BITS];
        o_v      = (i_a[BITS-1] == i_b[BITS-1]) && (w_result[BITS-1] != i_a[BITS-1]);
        o_cv_upd = 1'b1;
      end
      ALU_SUB: begin
        // a + ~b + 1: carry out set means no borrow.
        w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{BITS{1'b0}}, 1'b1};
        w_result = w_sum[BITS-1:0];
        o_c      = w_sum[BITS];
        o_v      = (i_a[BITS-1] != i_b[BITS-1]) && (w_result[BITS-1] != i_a[BITS-1]);
        o_cv_upd = 1'b1;
      end
      ALU_AND: w_result = i_a & i_b;
      ALU_ORR: w_result = i_a | i_b;
      ALU_EOR: w_result = i_a ^ i_b;
      ALU_MUL: w_result = i_mul_prod;
      ALU_MOV: w_result = i_b;
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_n      = w_result[BITS-1];
  assign o_z      = (w_result == '0);

endmodule

// File: rtl/execute_stage.sv
// execute_stage -- pipeline execute stage with forwarding, condition
// evaluation, NZCV flag register and the execute/memory pipeline register.
// Optional feature macro: EXEC_MUL_EN (two-cycle multiply sequencer).
//   Inputs : CLK, RST_N, RD1E/RD2E/ExtImmE operands, ALUControlE, controls
//            (ALUSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, PCSrcE,
//            NoWriteE, FlagWriteE), CondE, WA3E, ForwardAE/BE, ResultW.
//   Outputs: ALUResultM, WriteDataM, WA3M, RegWriteM, MemtoRegM, MemWriteM
//            (registered); PCSrcCondE, BranchTakenE, BranchTargetE
//            (combinational); FlagsQ; StallE; DbgStateE (sequencer state).
// Stall handshake: StallE is a combinational request valid in the cycle a
// conditional MUL is accepted from IDLE; the upstream register must hold
// its contents for that cycle, so the same instruction is presented again
// in BUSY, where it completes and StallE is low.
module execute_stage
  import exec_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [BITS-1:0] RD1E,
  input  logic [BITS-1:0] RD2E,
  input  logic [BITS-1:0] ExtImmE,
  input  logic [2:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            PCSrcE,
  input  logic            NoWriteE,
  input  logic [1:0]      FlagWriteE,
  input  logic [3:0]      CondE,
  input  logic [3:0]      WA3E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [BITS-1:0] ResultW,
  output logic [BITS-1:0] ALUResultM,
  output logic [BITS-1:0] WriteDataM,
  output logic            RegWriteM,
  output logic            MemtoRegM,
  output logic            MemWriteM,
  output logic [3:0]      WA3M,
  output logic            PCSrcCondE,
  output logic            BranchTakenE,
  output logic [BITS-1:0] BranchTargetE,
  output logic [3:0]      FlagsQ,
  output logic            StallE,
  output exec_state_t     DbgStateE
);

  logic [BITS-1:0] w_src_a;
  logic [BITS-1:0] w_src_b;
  logic [BITS-1:0] w_store;
  logic [BITS-1:0] w_alu_result;
  logic [BITS-1:0] w_mul_prod;
  logic            w_alu_n, w_alu_z, w_alu_c, w_alu_v, w_cv_upd;
  logic            w_cond_ex;
  logic            w_mul_start;
  logic            w_n, w_z, w_c, w_v;

  // Operand forwarding; ALUResultM is this stage's own output register.
  always_comb begin
    case (fwd_sel_t'(ForwardAE))
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = ALUResultM;
      default: w_src_a = RD1E;
    endcase
    case (fwd_sel_t'(ForwardBE))
      FWD_WB:  w_store = ResultW;
      FWD_MEM: w_store = ALUResultM;
      default: w_store = RD2E;
    endcase
    w_src_b = ALUSrcE ? ExtImmE : w_store;
  end

  assign w_n = FlagsQ[FLAG_N];
  assign w_z = FlagsQ[FLAG_Z];
  assign w_c = FlagsQ[FLAG_C];
  assign w_v = FlagsQ[FLAG_V];

  always_comb begin
    case (cond_t'(CondE))
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~w_c | w_z;
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      COND_AL: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  exec_state_t     r_state;
  logic [BITS-1:0] r_prod;
  logic [BITS-1:0] w_mul_lo;
  logic            w_busy;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_mul_lo = w_src_a * w_src_b;
  // Gated by RST_N so no stall is requested while the stage is held in reset.
  assign w_mul_start = RST_N & ~w_busy & (ALUControlE == ALU_MUL) & w_cond_ex;
  // The product is captured in the stall cycle so a change of the forwarded
  // ALUResultM (now a bubble) cannot disturb it in BUSY.
  assign w_mul_prod = w_busy ? r_prod : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_prod  <= '0;
    end else if (w_mul_start) begin
      r_state <= ST_BUSY;
      r_prod  <= w_mul_lo;
    end else if (w_busy) begin
      r_state <= ST_IDLE;
    end
  end

  assign DbgStateE = r_state;
`else
  assign w_mul_start = 1'b0;
  assign w_mul_prod  = '0;
  assign DbgStateE   = ST_IDLE;
`endif

  assign StallE = w_mul_start;

  exec_alu #(.BITS(BITS)) u_alu (
    .i_a        (w_src_a),
    .i_b        (w_src_b),
    .i_op       (ALUControlE),
    .i_mul_prod (w_mul_prod),
    .o_result   (w_alu_result),
    .o_n        (w_alu_n),
    .o_z        (w_alu_z),
    .o_c        (w_alu_c),
    .o_v        (w_alu_v),
    .o_cv_upd   (w_cv_upd)
  );

  assign BranchTargetE = w_alu_result;
  assign PCSrcCondE    = PCSrcE & w_cond_ex;
  assign BranchTakenE  = BranchE & w_cond_ex;

  // Execute/memory register; a starting multiply loads a bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
    end else if (w_mul_start) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
    end else begin
      ALUResultM <= w_alu_result;
      WriteDataM <= w_store;
      WA3M       <= WA3E;
      RegWriteM  <= RegWriteE & w_cond_ex & ~NoWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE & w_cond_ex;
    end
  end

  // Flags change only for executed instructions, never in a stall cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FlagsQ <= 4'b0000;
    end else if (w_cond_ex && !w_mul_start) begin
      if (FlagWriteE[1]) begin
        FlagsQ[FLAG_N] <= w_alu_n;
        FlagsQ[FLAG_Z] <= w_alu_z;
      end
      if (FlagWriteE[0] && w_cv_upd) begin
        FlagsQ[FLAG_C] <= w_alu_c;
        FlagsQ[FLAG_V] <= w_alu_v;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import exec_pkg::*;

  localparam int W = 32;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [W-1:0] RD1E, RD2E, ExtImmE, ResultW;
  logic [2:0]   ALUControlE;
  logic         ALUSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, PCSrcE, NoWriteE;
  logic [1:0]   FlagWriteE, ForwardAE, ForwardBE;
  logic [3:0]   CondE, WA3E;
  logic [W-1:0] ALUResultM, WriteDataM, BranchTargetE;
  logic         RegWriteM, MemtoRegM, MemWriteM, PCSrcCondE, BranchTakenE, StallE;
  logic [3:0]   WA3M, FlagsQ;
  exec_state_t  DbgStateE;

  execute_stage #(.BITS(W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .PCSrcE(PCSrcE), .NoWriteE(NoWriteE),
    .FlagWriteE(FlagWriteE), .CondE(CondE), .WA3E(WA3E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WA3M(WA3M), .PCSrcCondE(PCSrcCondE), .BranchTakenE(BranchTakenE),
    .BranchTargetE(BranchTargetE), .FlagsQ(FlagsQ), .StallE(StallE),
    .DbgStateE(DbgStateE)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [3:0]   m_flags;
  logic [W-1:0] m_alu_m;
  logic [W-1:0] m_prod;
  bit           m_busy;
  bit           last_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fwd(input logic [1:0] sel, input logic [W-1:0] rd);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return m_alu_m;
    return rd;
  endfunction

  // ARM view: even codes test a predicate, the following odd code negates it.
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, p;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: p = z;
      3'd1: p = c;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = c && !z;
      3'd5: p = (n == v);
      3'd6: p = !z && (n == v);
      default: p = 1'b1;
    endcase
    return cc[0] ? !p : p;
  endfunction

  // Arithmetic done on wide integers: carry is a bit above 2^32, overflow is
  // the exact signed result not fitting in 32 bits.
  function automatic void model_alu(input logic [2:0] op, input logic [W-1:0] a, b, mv,
                                    output logic [W-1:0] r, output bit c, v, cvu);
    longint ua, ub, sa, sb, s;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; cvu = 1'b0; r = '0;
    case (op)
      3'd0: begin
        r = a + b; s = sa + sb;
        c = ((ua + ub) >>> 32) != 0;
        v = (s != longint'($signed(r)));
        cvu = 1'b1;
      end
      3'd1: begin
        r = a - b; s = sa - sb;
        c = (ua >= ub);
        v = (s != longint'($signed(r)));
        cvu = 1'b1;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = mv;
      3'd6: r = b;
      default: r = '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_defaults();
    RD1E = '0; RD2E = '0; ExtImmE = '0; ResultW = '0;
    ALUControlE = 3'd0; ALUSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    BranchE = 0; PCSrcE = 0; NoWriteE = 0; FlagWriteE = 2'b00;
    CondE = 4'he; WA3E = 4'd0; ForwardAE = 2'd0; ForwardBE = 2'd0;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7fff_ffff;
      2: return 32'h8000_0000;
      3: return 32'hffff_ffff;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic randomize_inputs();
    RD1E = pick_val(); RD2E = pick_val(); ExtImmE = pick_val(); ResultW = pick_val();
    ALUControlE = 3'($urandom_range(0, 7));
    ALUSrcE = 1'($urandom_range(0, 1)); RegWriteE = 1'($urandom_range(0, 1));
    MemtoRegE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
    BranchE = 1'($urandom_range(0, 1)); PCSrcE = 1'($urandom_range(0, 1));
    NoWriteE = ($urandom_range(0, 3) == 0);
    FlagWriteE = 2'($urandom_range(0, 3));
    CondE = ($urandom_range(0, 1) == 1) ? 4'he : 4'($urandom_range(0, 15));
    WA3E = 4'($urandom_range(0, 15));
    ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
  endtask

  // One clock with the current inputs: predict, check combinational outputs
  // at the negedge, then registered outputs just after the posedge.
  task automatic run_cycle();
    logic [W-1:0] a, st, b, r, mv, e_alu, e_wd;
    logic [3:0]   e_wa;
    bit c, v, cvu, cond, stall, e_rw, e_mtr, e_mw;
    a = fwd(ForwardAE, RD1E);
    st = fwd(ForwardBE, RD2E);
    b = ALUSrcE ? ExtImmE : st;
    cond = cond_ok(CondE, m_flags);
    stall = MUL_EN && !m_busy && (ALUControlE == 3'd5) && cond;
    mv = m_busy ? m_prod : '0;
    model_alu(ALUControlE, a, b, mv, r, c, v, cvu);
    @(negedge CLK);
    last_stall = StallE;
    check("stall", 32'(StallE), 32'(stall));
    check("branch_target", BranchTargetE, r);
    check("pcsrc_cond", 32'(PCSrcCondE), 32'(PCSrcE && cond));
    check("branch_taken", 32'(BranchTakenE), 32'(BranchE && cond));
    @(posedge CLK);
    if (stall) begin
      m_prod = a * b;
      m_busy = 1'b1;
      e_alu = '0; e_wd = '0; e_wa = '0; e_rw = 0; e_mtr = 0; e_mw = 0;
    end else begin
      m_busy = 1'b0;
      e_alu = r; e_wd = st; e_wa = WA3E;
      e_rw = RegWriteE && cond && !NoWriteE;
      e_mtr = MemtoRegE;
      e_mw = MemWriteE && cond;
      if (cond) begin
        if (FlagWriteE[1]) begin
          m_flags[3] = r[W-1];
          m_flags[2] = (r == '0);
        end
        if (FlagWriteE[0] && cvu) begin
          m_flags[1] = c;
          m_flags[0] = v;
        end
      end
    end
    m_alu_m = e_alu;
    exp_q.push_back(e_alu);
    #1;
    check("alu_result_m", ALUResultM, exp_q.pop_front());
    check("write_data_m", WriteDataM, e_wd);
    check("wa3_m", 32'(WA3M), 32'(e_wa));
    check("reg_write_m", 32'(RegWriteM), 32'(e_rw));
    check("memtoreg_m", 32'(MemtoRegM), 32'(e_mtr));
    check("mem_write_m", 32'(MemWriteM), 32'(e_mw));
    check("flags", 32'(FlagsQ), 32'(m_flags));
    check("fsm_state", 32'(DbgStateE), 32'(m_busy));
  endtask

  task automatic check_reset_outputs();
    check("rst_alu_result", ALUResultM, 32'h0);
    check("rst_write_data", WriteDataM, 32'h0);
    check("rst_wa3", 32'(WA3M), 32'h0);
    check("rst_reg_write", 32'(RegWriteM), 32'h0);
    check("rst_memtoreg", 32'(MemtoRegM), 32'h0);
    check("rst_mem_write", 32'(MemWriteM), 32'h0);
    check("rst_flags", 32'(FlagsQ), 32'h0);
    check("rst_stall", 32'(StallE), 32'h0);
    check("rst_state", 32'(DbgStateE), 32'(ST_IDLE));
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Flags chain from row to row (AL, FlagWriteE=11); NZCV hand-derived.
    tbl[0]  = '{3'd0, 32'd5,          32'd5,          32'd10,         4'b0000};
    tbl[1]  = '{3'd1, 32'd5,          32'd5,          32'd0,          4'b0110};
    tbl[2]  = '{3'd0, 32'h7fff_ffff,  32'd1,          32'h8000_0000,  4'b1001};
    tbl[3]  = '{3'd1, 32'd0,          32'd1,          32'hffff_ffff,  4'b1000};
    tbl[4]  = '{3'd0, 32'hffff_ffff,  32'd1,          32'd0,          4'b0110};
    tbl[5]  = '{3'd2, 32'h0000_f0f0,  32'h0000_0ff0,  32'h0000_00f0,  4'b0010};
    tbl[6]  = '{3'd3, 32'h8000_0000,  32'd1,          32'h8000_0001,  4'b1010};
    tbl[7]  = '{3'd4, 32'h0000_aaaa,  32'h0000_aaaa,  32'd0,          4'b0110};
    tbl[8]  = '{3'd6, 32'h0000_ffff,  32'h0000_1234,  32'h0000_1234,  4'b0010};
    tbl[9]  = '{3'd7, 32'd9,          32'd9,          32'd0,          4'b0110};
    tbl[10] = '{3'd1, 32'h8000_0000,  32'd1,          32'h7fff_ffff,  4'b0011};
    tbl[11] = '{3'd0, 32'h8000_0000,  32'h8000_0000,  32'd0,          4'b0111};

    RST_N = 1'b0;
    set_defaults();
    m_flags = '0; m_alu_m = '0; m_prod = '0; m_busy = 0; last_stall = 0;
    #3;
    check_reset_outputs();
    @(posedge CLK); #2 RST_N = 1'b1;

    // table-driven ALU/flag vectors
    for (int i = 0; i < 12; i++) begin
      set_defaults();
      ALUControlE = tbl[i].op; RD1E = tbl[i].a; RD2E = tbl[i].b;
      FlagWriteE = 2'b11; RegWriteE = 1'b1; WA3E = 4'(i);
      run_cycle();
      check("tbl_result", ALUResultM, tbl[i].res);
      check("tbl_flags", 32'(FlagsQ), 32'(tbl[i].flags));
      check("tbl_reg_write", 32'(RegWriteM), 32'h1);
    end

    // overflow then VS / VC / NoWrite gating
    set_defaults();
    ALUControlE = 3'd0; RD1E = 32'h7fff_ffff; RD2E = 32'd1; FlagWriteE = 2'b11;
    run_cycle();
    check("ovf_flags", 32'(FlagsQ), 32'b1001);
    set_defaults(); RegWriteE = 1; CondE = 4'h6; RD1E = 32'd1; RD2E = 32'd2;
    run_cycle();
    check("vs_reg_write", 32'(RegWriteM), 32'h1);
    CondE = 4'h7;
    run_cycle();
    check("vc_reg_write", 32'(RegWriteM), 32'h0);
    CondE = 4'he; NoWriteE = 1;
    run_cycle();
    check("nowrite_reg_write", 32'(RegWriteM), 32'h0);
    set_defaults(); ALUControlE = 3'd1; RD1E = 32'd5; RD2E = 32'd5;
    FlagWriteE = 2'b11; CondE = 4'h7;
    run_cycle();
    check("failed_cond_flags_hold", 32'(FlagsQ), 32'b1001);

    // forwarding
    set_defaults(); RD1E = 32'h10;
    run_cycle();
    set_defaults(); ForwardAE = 2'b10; RD1E = 32'h99; ALUSrcE = 1; ExtImmE = 32'd1;
    run_cycle();
    check("fwd_mem_a", ALUResultM, 32'h11);
    set_defaults(); ForwardBE = 2'b01; ResultW = 32'h44; RD2E = 32'h55;
    ALUSrcE = 1; MemWriteE = 1;
    run_cycle();
    check("fwd_wb_store", WriteDataM, 32'h44);
    check("fwd_mem_write", 32'(MemWriteM), 32'h1);

    // multiply
    set_defaults(); ALUControlE = 3'd5; RD1E = 32'd6; RD2E = 32'd7; RegWriteE = 1;
`ifdef EXEC_MUL_EN
    run_cycle();
    check("mul_stall", 32'(last_stall), 32'h1);
    check("mul_bubble", 32'(RegWriteM), 32'h0);
    run_cycle();
    check("mul_busy_stall", 32'(last_stall), 32'h0);
    check("mul_result", ALUResultM, 32'd42);
    check("mul_reg_write", 32'(RegWriteM), 32'h1);
`else
    run_cycle();
    check("mul_off_stall", 32'(last_stall), 32'h0);
    check("mul_off_result", ALUResultM, 32'd0);
`endif

    // asynchronous reset in the middle of an operation (BUSY when enabled)
    set_defaults(); ALUControlE = 3'd5; RD1E = 32'd6; RD2E = 32'd7;
    RegWriteE = 1; FlagWriteE = 2'b11;
    run_cycle();
    #1 RST_N = 1'b0;
    #1 check_reset_outputs();
    m_flags = '0; m_alu_m = '0; m_busy = 0;
    @(posedge CLK); #2 RST_N = 1'b1;
    set_defaults(); RD1E = 32'd2; RD2E = 32'd3; RegWriteE = 1;
    run_cycle();
    check("post_reset_add", ALUResultM, 32'd5);

    // randomized against the model; inputs held while the multiply is BUSY
    for (int i = 0; i < 300; i++) begin
      if (!m_busy) randomize_inputs();
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
